if_id_queue: RTL and testbench
==============================

# if_id_queue

Decoupling instruction queue between the fetch stage and the decode stage. It captures each fetched {PC, instruction} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. Its `ready` output throttles the fetch PC register. A redirect flush discards every buffered instruction in one cycle, so a stall in decode no longer forces fetch to stop in lock-step.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- NOP_INSTR, 32'h0000_0013, instruction word driven when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- IFQ_pc_i  input  32  PC of the fetched instruction (fetch PC register output).
- IFQ_instr_i  input  32  fetched instruction word.
- IFQ_valid_i  input  1  fetch presents a valid pair this cycle.
- IFQ_ready_o  output  1  queue can accept a pair this cycle; gates the fetch PC register load.
- IFQ_flush_i  input  1  control-flow redirect; drop all contents and this cycle's input.
- IFQ_pc_o  output  32  PC of the head entry.
- IFQ_instr_o  output  32  instruction of the head entry.
- IFQ_valid_o  output  1  head entry valid.
- IFQ_ready_i  input  1  decode consumes the head this cycle.
- IFQ_count_o  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- State:
  - DEPTH x 64-bit storage array.
  - Read and write pointers, log2(DEPTH) bits each, wrapping modulo DEPTH.
  - Occupancy counter, 0..DEPTH.
- Outputs:
  - IFQ_ready_o = (count != DEPTH). It is purely a function of registered count, with no dependence on IFQ_ready_i.
  - IFQ_valid_o = (count != 0).
- Enqueue condition: IFQ_valid_i && IFQ_ready_o && !IFQ_flush_i. On enqueue, write {pc, instr} at wptr and increment wptr.
- Dequeue condition: IFQ_valid_o && IFQ_ready_i && !IFQ_flush_i. On dequeue, increment rptr.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged when both occur.
- Full queue: enqueue is blocked even if decode dequeues in the same cycle. There is no full-bypass.
- Empty queue: there is no input-to-output bypass. A pair enqueued into an empty queue appears at the output one cycle later.
- Head outputs:
  - count = 0: IFQ_pc_o = 32'h0 and IFQ_instr_o = NOP_INSTR.
  - Otherwise: the stored entry at rptr.
- Flush:
  - At the next edge, rptr = wptr = 0 and count = 0.
  - The incoming pair and the head are both discarded.
  - Storage contents are don't-care.
- Reset:
  - At the next edge, rptr = wptr = 0 and count = 0.
  - Outputs after reset: IFQ_valid_o = 0, IFQ_ready_o = 1, IFQ_count_o = 0, IFQ_pc_o = 0, IFQ_instr_o = NOP_INSTR.
  - rst has priority over flush, enqueue and dequeue.
- Integration: the fetch PC register load enable = IFQ_ready_o | IFQ_flush_i. This lets a redirect target load even when the queue is full.

## Timing
- Latency: a pair enqueued at edge N is visible on the outputs, with IFQ_valid_o = 1, during cycle N+1.
- IFQ_ready_o updates on the edge after count reaches or leaves DEPTH. There is no same-cycle combinational path from IFQ_ready_i.
- Flush asserted in cycle N: during cycle N+1, IFQ_valid_o = 0, IFQ_ready_o = 1 and IFQ_count_o = 0. Enqueue resumes in cycle N+1.
- Sustained throughput is one pair per cycle when decode accepts every cycle (count holds steady).
- Pointer wrap: after DEPTH enqueues, wptr returns to 0. Order must be preserved across the wrap.
- Decode must sample IFQ_pc_o and IFQ_instr_o only when IFQ_valid_o = 1.
- Rule for upstream: it must hold a pair stable while IFQ_valid_i && !IFQ_ready_o. The queue never drops a pair except on flush.

## Test plan
- Reset: assert rst for 2 cycles with IFQ_valid_i = 1.
  - Required: IFQ_valid_o = 0, IFQ_ready_o = 1, count = 0, IFQ_pc_o = 0, IFQ_instr_o = 32'h13. Nothing is enqueued.
- Fill (DEPTH = 4), with IFQ_ready_i = 0:
  - Stimulus: enqueue PCs 0x0, 0x4, 0x8, 0xC with instrs 0xA0..0xA3.
  - Required: count goes 1, 2, 3, 4. IFQ_ready_o = 0 from the cycle after the 4th enqueue. A 5th pair held on the input is not accepted.
  - Follow-on: then raise IFQ_ready_i. Outputs drain in order 0x0, 0x4, 0x8, 0xC, and ready_o returns to 1 one cycle after the first dequeue.
- Streaming:
  - Stimulus: IFQ_valid_i = 1 and IFQ_ready_i = 1 for 10 cycles, with PC incrementing by 4 from 0x100.
  - Required: the output follows the input with 1-cycle latency. count stays at 1 after the first cycle. Wrap occurs with no reorder or loss.
- Simultaneous events when full:
  - Stimulus: with count = 4, assert IFQ_ready_i = 1 and IFQ_valid_i = 1 in the same cycle.
  - Required: a dequeue occurs, no enqueue, and count becomes 3. The input pair is accepted next cycle, so count stays at 3.
- Flush mid-stream:
  - Stimulus: with count = 3, assert IFQ_flush_i for one cycle with IFQ_valid_i = 1 (PC 0x200) and IFQ_ready_i = 1.
  - Required: next cycle, count = 0, IFQ_valid_o = 0 and IFQ_instr_o = NOP. PC 0x200 is discarded. The redirect pair PC 0x400 is enqueued the following cycle.
- Reset mid-operation:
  - Stimulus: assert rst with count = 2 together with flush, valid and ready.
  - Required: the reset values above are reached after one edge.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {PC, instr} pairs with
// valid/ready on both sides and a single-cycle redirect flush.
module if_id_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                IFQ_pc_i,
    input  logic [31:0]                IFQ_instr_i,
    input  logic                       IFQ_valid_i,
    output logic                       IFQ_ready_o,
    input  logic                       IFQ_flush_i,
    output logic [31:0]                IFQ_pc_o,
    output logic [31:0]                IFQ_instr_o,
    output logic                       IFQ_valid_o,
    input  logic                       IFQ_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] IFQ_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [63:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_enq;
    logic w_deq;
    logic [63:0] w_head;

    // Ready depends only on registered occupancy, so a full queue never bypasses.
    assign IFQ_ready_o = (r_count != CNT_W'(DEPTH));
    assign IFQ_valid_o = (r_count != '0);
    assign IFQ_count_o = r_count;

    assign w_enq = IFQ_valid_i && IFQ_ready_o && !IFQ_flush_i;
    assign w_deq = IFQ_valid_o && IFQ_ready_i && !IFQ_flush_i;

    assign w_head = r_mem[r_rptr];

    always_comb begin
        IFQ_pc_o    = 32'h0;
        IFQ_instr_o = NOP_INSTR;
        if (IFQ_valid_o) begin
            IFQ_pc_o    = w_head[63:32];
            IFQ_instr_o = w_head[31:0];
        end
    end

    // Storage needs no reset; empty-queue outputs are forced above.
    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            r_mem[r_wptr] <= {IFQ_pc_i, IFQ_instr_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || IFQ_flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IFQ_pc_i;
    logic [31:0] IFQ_instr_i;
    logic        IFQ_valid_i;
    logic        IFQ_ready_o;
    logic        IFQ_flush_i;
    logic [31:0] IFQ_pc_o;
    logic [31:0] IFQ_instr_o;
    logic        IFQ_valid_o;
    logic        IFQ_ready_i;
    logic [2:0]  IFQ_count_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mq[$];
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .IFQ_pc_i    (IFQ_pc_i),
        .IFQ_instr_i (IFQ_instr_i),
        .IFQ_valid_i (IFQ_valid_i),
        .IFQ_ready_o (IFQ_ready_o),
        .IFQ_flush_i (IFQ_flush_i),
        .IFQ_pc_o    (IFQ_pc_o),
        .IFQ_instr_o (IFQ_instr_o),
        .IFQ_valid_o (IFQ_valid_o),
        .IFQ_ready_i (IFQ_ready_i),
        .IFQ_count_o (IFQ_count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_pc;
        logic [31:0] e_in;
        e_pc = 32'h0;
        e_in = NOP;
        if (mq.size() != 0) begin
            e_pc = mq[0][63:32];
            e_in = mq[0][31:0];
        end
        check("valid_o", {31'b0, IFQ_valid_o}, {31'b0, mq.size() != 0});
        check("ready_o", {31'b0, IFQ_ready_o}, {31'b0, mq.size() != DEPTH});
        check("count_o", {29'b0, IFQ_count_o}, mq.size());
        check("pc_o", IFQ_pc_o, e_pc);
        check("instr_o", IFQ_instr_o, e_in);
    endtask

    // Drive one cycle's inputs at the falling edge, check, then advance the model.
    task automatic cyc(input logic r, input logic f, input logic v,
                       input logic [31:0] pc, input logic [31:0] ins, input logic rd);
        bit m_ready;
        bit m_enq;
        bit m_deq;
        rst = r; IFQ_flush_i = f; IFQ_valid_i = v;
        IFQ_pc_i = pc; IFQ_instr_i = ins; IFQ_ready_i = rd;
        if (chk_en) check_outputs();
        m_ready = (mq.size() != DEPTH);
        m_enq   = v && m_ready && !f;
        m_deq   = (mq.size() != 0) && rd && !f;
        @(posedge clk);
        if (r || f) begin
            mq.delete();
        end else begin
            if (m_deq) void'(mq.pop_front());
            if (m_enq) mq.push_back({pc, ins});
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; IFQ_flush_i = 1'b0; IFQ_valid_i = 1'b1;
        IFQ_pc_i = 32'hdead_0000; IFQ_instr_i = 32'hbeef; IFQ_ready_i = 1'b0;
        @(negedge clk);

        // Reset for two cycles with valid held high: nothing enqueued.
        cyc(1, 0, 1, 32'hdead_0000, 32'hbeef, 0);
        cyc(1, 0, 1, 32'hdead_0004, 32'hbeef, 0);
        chk_en = 1'b1;
        check("rst_valid", {31'b0, IFQ_valid_o}, 32'd0);
        check("rst_ready", {31'b0, IFQ_ready_o}, 32'd1);
        check("rst_instr", IFQ_instr_o, 32'h13);

        // Fill to DEPTH, then hold a 5th pair that must not be accepted.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'(4 * i), 32'hA0 + 32'(i), 0);
        check("full_ready", {31'b0, IFQ_ready_o}, 32'd0);
        cyc(0, 0, 1, 32'h10, 32'hA4, 0);
        cyc(0, 0, 1, 32'h10, 32'hA4, 0);
        check("full_count", {29'b0, IFQ_count_o}, 32'd4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 32'h0, 1);
        check("drained", {29'b0, IFQ_count_o}, 32'd0);

        // Streaming across the pointer wrap.
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i), 1);
        check("stream_cnt", {29'b0, IFQ_count_o}, 32'd1);
        cyc(0, 0, 0, 32'h0, 32'h0, 1);

        // Full with simultaneous enqueue and dequeue.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h300 + 32'(4 * i), 32'hC0 + 32'(i), 0);
        cyc(0, 0, 1, 32'h310, 32'hC4, 1);
        check("full_simul", {29'b0, IFQ_count_o}, 32'd3);
        cyc(0, 0, 1, 32'h314, 32'hC5, 1);
        check("steady3", {29'b0, IFQ_count_o}, 32'd3);

        // Flush mid-stream, then the redirect pair.
        cyc(0, 1, 1, 32'h200, 32'hD0, 1);
        check("flush_cnt", {29'b0, IFQ_count_o}, 32'd0);
        check("flush_nop", IFQ_instr_o, NOP);
        cyc(0, 0, 1, 32'h400, 32'hD1, 0);
        check("redirect_pc", IFQ_pc_o, 32'h400);

        // Reset with everything else asserted.
        cyc(0, 0, 1, 32'h404, 32'hD2, 0);
        cyc(1, 1, 1, 32'h408, 32'hD3, 1);
        check("rst_mid_cnt", {29'b0, IFQ_count_o}, 32'd0);

        // Random traffic; upstream holds its pair while stalled.
        begin
            logic [31:0] pc;
            logic [31:0] ins;
            logic        v;
            pc = 32'h1000; ins = $urandom; v = 1'b0;
            for (int i = 0; i < 600; i++) begin
                logic r;
                logic f;
                logic rd;
                r  = ($urandom_range(63) == 0);
                f  = ($urandom_range(15) == 0);
                rd = ($urandom_range(9) < 6);
                if (!(v && !IFQ_ready_o) || f || r) begin
                    v   = ($urandom_range(9) < 7);
                    pc  = pc + 32'd4;
                    ins = $urandom;
                end
                cyc(r, f, v, pc, ins, rd);
            end
        end
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
